// File: rtl/swt_debounce.sv
// Purpose: synchronize and debounce the raw slide-switch bus, with per-bit rise/fall strobes.
// Latency: a clean raw change appears on swt_db on edge DEBOUNCE_CYCLES+2 (2 sync + full count).
// Backpressure: none; free-running conditioner, strobes are single-cycle and cannot be stalled.
module swt_debounce #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] swt,
  output logic [WIDTH-1:0] swt_db,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] strobe_nxt;

  // Two-flop synchronizer for the asynchronous switch pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= swt;
      s2 <= s1;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : gen_bit
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Per-bit state, counter, debounced level and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        db_q    <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        db_q    <= db_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    // Next state: count consecutive cycles the synchronized level differs from the
    // accepted level; any agreement in between restarts from zero.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      db_d    = db_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
        IDLE: begin
          if (s2[gi] != db_q) begin
            state_d = PENDING;
            cnt_d   = CNT_ONE;
          end
        end
        PENDING: begin
          if (s2[gi] == db_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            db_d    = s2[gi];
            rise_d  = s2[gi];
            fall_d  = ~s2[gi];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign swt_db[gi]     = db_q;
    assign rise[gi]       = rise_q;
    assign fall[gi]       = fall_q;
    assign strobe_nxt[gi] = rise_d | fall_d;
  end

  // Combined change flag, registered alongside the per-bit strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |strobe_nxt;
    end
  end

endmodule

// File: tb/tb_swt_debounce.sv
module tb_swt_debounce;

  localparam int W  = 3;
  localparam int DC = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] swt;
  logic [W-1:0] swt_db;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         any_change;

  swt_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .rst        (rst),
    .swt        (swt),
    .swt_db     (swt_db),
    .rise       (rise),
    .fall       (fall),
    .any_change (any_change)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    int unsigned  edge_n;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [W-1:0] hist[$];   // raw swt value seen at each edge since reset release
  logic [W-1:0] m_db = '0;
  int unsigned  cur_edge = 0;

  // Level presented to the decision logic j edges ago: raw sample from two edges earlier.
  function automatic logic [W-1:0] s2_at(int j);
    int idx;
    idx = hist.size() - 3 - j;
    if (idx >= 0) return hist[idx];
    return '0;
  endfunction

  // A bit is accepted when the synchronized level over the last DC edges was one
  // constant value different from the currently accepted level.
  always @(posedge clk or posedge rst) begin : model
    logic [W-1:0] r, f, w;
    logic         v, same;
    if (rst) begin
      hist.delete();
      sb.delete();
      m_db = '0;
    end else begin
      cur_edge++;
      hist.push_back(swt);
      if (hist.size() > DC + 3) void'(hist.pop_front());
      r = '0;
      f = '0;
      for (int i = 0; i < W; i++) begin
        w    = s2_at(0);
        v    = w[i];
        same = 1'b1;
        for (int j = 1; j < DC; j++) begin
          w = s2_at(j);
          if (w[i] != v) same = 1'b0;
        end
        if (same && (v != m_db[i])) begin
          m_db[i] = v;
          r[i]    = v;
          f[i]    = ~v;
        end
      end
      if ((r | f) != '0) sb.push_back('{cur_edge, r, f});
    end
  end

  // Monitor: compares the level every cycle and consumes an expected strobe whenever
  // the DUT shows one or one is due.
  always @(negedge clk) begin
    if (!rst) begin
      chk("swt_db", swt_db, m_db);
      if (any_change || (sb.size() > 0 && sb[0].edge_n <= cur_edge)) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", any_change, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("strobe_any_change", any_change, 1);
          chk("strobe_rise", rise, mon_e.rise);
          chk("strobe_fall", fall, mon_e.fall);
        end
      end else begin
        chk("quiet_strobes", {rise, fall}, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    swt = '0;
    wait_neg(3);
    chk("reset_swt_db", swt_db, 0);
    chk("reset_rise", rise, 0);
    chk("reset_fall", fall, 0);
    chk("reset_any_change", any_change, 0);
    rst = 1'b0;

    // Reach a non-zero state, then reset asynchronously mid-cycle.
    swt = 3'b111;
    wait_neg(8);
    chk("pre_reset_db", swt_db, 3'b111);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_reset_db", swt_db, 0);
    chk("async_reset_rise", rise, 0);
    chk("async_reset_any", any_change, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_neg(5);
    chk("rel_db_edge5", swt_db, 0);
    wait_neg(1);
    chk("rel_db_edge6", swt_db, 3'b111);
    chk("rel_rise_edge6", rise, 3'b111);
    chk("rel_any_edge6", any_change, 1);
    wait_neg(1);
    chk("rel_any_edge7", any_change, 0);

    swt = 3'b000;
    wait_neg(10);

    // Clean single-bit edges.
    swt = 3'b001;
    wait_neg(5);
    chk("clean_db_edge5", swt_db, 0);
    wait_neg(1);
    chk("clean_db_edge6", swt_db, 3'b001);
    chk("clean_rise", rise, 3'b001);
    chk("clean_fall_none", fall, 0);
    wait_neg(4);
    swt = 3'b000;
    wait_neg(6);
    chk("clean_fall", fall, 3'b001);
    chk("clean_fall_db", swt_db, 0);
    wait_neg(4);

    // Bounce shorter than the debounce window is rejected.
    swt = 3'b010; wait_neg(3);
    swt = 3'b000; wait_neg(1);
    swt = 3'b010; wait_neg(2);
    swt = 3'b000; wait_neg(10);
    chk("bounce_rejected", swt_db, 0);
    swt = 3'b010;
    wait_neg(6);
    chk("bounce_then_accept", swt_db, 3'b010);
    swt = 3'b000;
    wait_neg(10);

    // Simultaneous acceptance on two bits.
    swt = 3'b101;
    wait_neg(5);
    chk("simul_db_edge5", swt_db, 0);
    wait_neg(1);
    chk("simul_db", swt_db, 3'b101);
    chk("simul_rise", rise, 3'b101);
    chk("simul_any", any_change, 1);
    wait_neg(1);
    chk("simul_any_single", any_change, 0);
    swt = 3'b000;
    wait_neg(10);

    // Reset in the middle of a count.
    swt = 3'b100;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    wait_neg(2);
    chk("midrst_rise", rise, 0);
    chk("midrst_db", swt_db, 0);
    rst = 1'b0;
    wait_neg(5);
    chk("midrst_edge5_db", swt_db, 0);
    chk("midrst_edge5_rise", rise, 0);
    wait_neg(1);
    chk("midrst_edge6_db", swt_db, 3'b100);
    chk("midrst_edge6_rise", rise, 3'b100);
    swt = 3'b000;
    wait_neg(10);

    // Exhaustive switch patterns feeding the downstream gate function.
    for (int v = 0; v < 8; v++) begin
      logic [W-1:0] pat;
      pat = W'(v);
      swt = pat;
      wait_neg(6);
      chk("exh_db", swt_db, pat);
      chk("exh_gate_d", (swt_db[2] | swt_db[1]) & swt_db[0], (pat[2] | pat[1]) & pat[0]);
    end

    // Random bouncy stimulus against the model.
    for (int s = 0; s < 120; s++) begin
      swt = W'($urandom);
      wait_neg($urandom_range(1, 7));
    end
    wait_neg(12);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/swt_debounce.md
# swt_debounce

Input-side conditioner for the board slide switches: takes the raw, asynchronous, bouncy `swt` bus and produces a synchronized, debounced copy for the gate-level lab logic. Its outputs drive the combinational datapath inputs (A/B/C style). It also produces one-cycle rise/fall strobes per switch. It sits between the top-level switch pins and the lab logic, opposite the LED output path.

## Interface
- `WIDTH`, 3, number of switch bits conditioned; bit i is independent of every other bit.
- `DEBOUNCE_CYCLES`, 1000, consecutive clock cycles a new level must persist before acceptance; legal range 2..65535.
- `clk`  input  1  system clock, all state on rising edge.
- `rst`  input  1  asynchronous, active-high reset; clears all state immediately.
- `swt`  input  WIDTH  raw switch levels, asynchronous to `clk`.
- `swt_db`  output  WIDTH  debounced switch levels.
- `rise`  output  WIDTH  one-cycle strobe per bit when `swt_db[i]` goes 0→1.
- `fall`  output  WIDTH  one-cycle strobe per bit when `swt_db[i]` goes 1→0.
- `any_change`  output  1  OR of all `rise` and `fall` bits, same cycle.

## Operation
- Per bit: a 2-flop synchronizer (`s1`, `s2`), a saturating-free counter of width ceil(log2(DEBOUNCE_CYCLES)), and the registered `swt_db[i]`.
- Per-bit state machine, two states:
  - IDLE: `s2 == swt_db`, counter = 0.
  - PENDING: `s2 != swt_db`, counter counting.
- Transitions on each rising edge:
  - IDLE → PENDING: `s2 != swt_db`; counter ← 1.
  - PENDING, `s2 == swt_db` (bounce back): → IDLE; counter ← 0; no strobe.
  - PENDING, `s2 != swt_db`, counter < DEBOUNCE_CYCLES−1: counter ← counter+1.
  - PENDING, `s2 != swt_db`, counter == DEBOUNCE_CYCLES−1: `swt_db[i]` ← `s2`; counter ← 0; → IDLE; assert `rise[i]` or `fall[i]` for exactly this next cycle.
- Counter never exceeds DEBOUNCE_CYCLES−1 and never wraps.
- Strobes are registered. They are asserted on the same edge that updates `swt_db` and deasserted on the following edge.
- Bits operate fully independently. Simultaneous acceptance on several bits gives several strobe bits in the same cycle and a single `any_change` cycle.
- All outputs are registered; there is no combinational path from `swt` to any output.

## Timing
- Reset values: `s1`, `s2`, counters, `swt_db`, `rise`, `fall`, `any_change` all 0. They take effect asynchronously on `rst` assertion and are held while `rst` is high.
- Reset deassertion: the first active edge is the first edge with `rst` low. A switch already high at release is accepted after the full latency, with a `rise` strobe.
- Latency: take a raw change that is clean from sampling edge 1 (the edge where `s1` captures it). `swt_db` updates on edge DEBOUNCE_CYCLES+2. Example: 6 edges for DEBOUNCE_CYCLES=4.
- Any reversion of `s2` before acceptance restarts the full count from the next differing cycle.
- Reset mid-count: the count is discarded; no strobe is emitted during or after reset for the aborted transition.
- Minimum accepted pulse width on `swt`: DEBOUNCE_CYCLES cycles. Shorter pulses are fully rejected.

## Test plan
Run with WIDTH=3, DEBOUNCE_CYCLES=4.
- Reset: assert `rst` asynchronously mid-cycle with `swt`=3'b111 → all outputs 0 immediately, before the next edge. Then deassert `rst` → `swt_db`=3'b111 on edge 6, `rise`=3'b111 and `any_change`=1 for one cycle.
- Clean edge: `swt[0]` 0→1 held → `swt_db[0]`=1 on edge 6 after sampling, `rise[0]` high one cycle, `fall`=0. Release to 0 held → `fall[0]` one cycle.
- Bounce: `swt[1]` high 3 cycles, low 1, high 2, low → `swt_db[1]` stays 0, no strobes. Then high ≥6 cycles → accepted.
- Simultaneous: `swt` 3'b000→3'b101 on the same edge → `swt_db`=3'b101 on edge 6, `rise`=3'b101, single `any_change` pulse.
- Reset mid-count: `swt[2]` high; assert `rst` on edge 4 → no `rise[2]` ever for that attempt. After release, acceptance occurs 6 edges later.
- Exhaustive: apply `swt`=0..7, each held 60 ns at 10 ns clk → after settle, `swt_db` equals the applied value and `(swt_db[2]|swt_db[1])&swt_db[0]` matches the downstream D.
